des_round_merge: RTL and testbench

DES_ROUND_MERGE -- requirements
Module: des_round_merge

---
 rtl/des_round_merge.sv | 149 ++++++++++++++
 tb/tb_des_round_merge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/des_round_merge.sv
// DES round merge: P-permutes the S-box word, XORs it into L and swaps halves (no swap on LAST_ROUND).
// Latency 1 cycle from acceptance to out_valid. Holds the result while out_ready is low.
// DES_MERGE_SKID_EN selects a 2-entry skid buffer with registered in_ready; default is a single output register.
module des_round_merge #(
  parameter logic [3:0] LAST_ROUND = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] sbox_out,
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [3:0]  round_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] l_out,
  output logic [31:0] r_out,
  output logic [3:0]  round_out
);

  // DES P permutation: output bit i (1 = MSB) takes input bit P[i], i.e. vector bit 32-P[i]
  logic [31:0] f;
  assign f = {sbox_out[16], sbox_out[25], sbox_out[12], sbox_out[11],
              sbox_out[3],  sbox_out[20], sbox_out[4],  sbox_out[15],
              sbox_out[31], sbox_out[17], sbox_out[9],  sbox_out[6],
              sbox_out[27], sbox_out[14], sbox_out[1],  sbox_out[22],
              sbox_out[30], sbox_out[24], sbox_out[8],  sbox_out[18],
              sbox_out[0],  sbox_out[5],  sbox_out[29], sbox_out[23],
              sbox_out[13], sbox_out[19], sbox_out[2],  sbox_out[26],
              sbox_out[10], sbox_out[21], sbox_out[28], sbox_out[7]};

  logic [31:0] nxt_l;
  logic [31:0] nxt_r;

  // Feistel merge; the last round keeps the halves in place
  always_comb begin
    nxt_l = r_in;
    nxt_r = l_in ^ f;
    if (round_in == LAST_ROUND) begin
      nxt_l = l_in ^ f;
      nxt_r = r_in;
    end
  end

  logic accept;
  logic retire;

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready;

`ifdef DES_MERGE_SKID_EN
  // Head of the buffer lives in l_out/r_out/round_out; the second entry is the skid slot.
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic        rdy_q;
  logic [31:0] skid_l;
  logic [31:0] skid_r;
  logic [3:0]  skid_round;

  // rdy_q resets high (buffer empty) but is masked while reset is asserted
  assign in_ready  = rst_n & rdy_q;
  assign out_valid = (count != 2'd0);

  // Occupancy after this cycle's accept/retire; simultaneous accept and retire cancel
  always_comb begin
    count_nxt = count;
    if (accept && !retire) begin
      count_nxt = count + 2'd1;
    end else if (retire && !accept) begin
      count_nxt = count - 2'd1;
    end
  end

  // Occupancy, registered ready, and data movement between head and skid slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= 2'd0;
      rdy_q      <= 1'b1;
      l_out      <= 32'd0;
      r_out      <= 32'd0;
      round_out  <= 4'd0;
      skid_l     <= 32'd0;
      skid_r     <= 32'd0;
      skid_round <= 4'd0;
    end else begin
      count <= count_nxt;
      rdy_q <= (count_nxt != 2'd2);
      case ({accept, retire})
        2'b10: begin
          if (count == 2'd0) begin
            l_out     <= nxt_l;
            r_out     <= nxt_r;
            round_out <= round_in;
          end else begin
            skid_l     <= nxt_l;
            skid_r     <= nxt_r;
            skid_round <= round_in;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            l_out     <= skid_l;
            r_out     <= skid_r;
            round_out <= skid_round;
          end
        end
        2'b11: begin
          if (count == 2'd2) begin
            l_out      <= skid_l;
            r_out      <= skid_r;
            round_out  <= skid_round;
            skid_l     <= nxt_l;
            skid_r     <= nxt_r;
            skid_round <= round_in;
          end else begin
            l_out     <= nxt_l;
            r_out     <= nxt_r;
            round_out <= round_in;
          end
        end
        default: begin
        end
      endcase
    end
  end
`else
  // Single output register: free when empty or being drained this cycle
  assign in_ready = rst_n & (~out_valid | out_ready);

  // Load on accept, clear valid on a retire with no replacement
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      l_out     <= 32'd0;
      r_out     <= 32'd0;
      round_out <= 4'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      l_out     <= nxt_l;
      r_out     <= nxt_r;
      round_out <= round_in;
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_des_round_merge.sv
// Self-checking bench for des_round_merge: vector table, corner sequences, randomized traffic.
// Reference model keeps expected results in a queue in acceptance order.
// Runs against either build of the buffer option.
module tb_des_round_merge;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sbox_out;
  logic [31:0] l_in;
  logic [31:0] r_in;
  logic [3:0]  round_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] l_out;
  logic [31:0] r_out;
  logic [3:0]  round_out;

  des_round_merge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sbox_out  (sbox_out),
    .l_in      (l_in),
    .r_in      (r_in),
    .round_in  (round_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .l_out     (l_out),
    .r_out     (r_out),
    .round_out (round_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic [3:0]  rd;
  } res_t;

  typedef struct {
    logic [31:0] sb;
    logic [31:0] l;
    logic [31:0] r;
    logic [3:0]  rd;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   rt_cnt = 0;
  res_t exp_q[$];
  int   ptab[32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  vec_t tab[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] perm(input logic [31:0] s);
    logic [31:0] o;
    o = '0;
    for (int i = 1; i <= 32; i++) o[32-i] = s[32-ptab[i-1]];
    return o;
  endfunction

  function automatic res_t model(input logic [31:0] sb, input logic [31:0] l, input logic [31:0] r,
                                 input logic [3:0] rd);
    res_t x;
    if (rd == 4'd15) begin
      x.l = l ^ perm(sb);
      x.r = r;
    end else begin
      x.l = r;
      x.r = l ^ perm(sb);
    end
    x.rd = rd;
    return x;
  endfunction

  // Called at a falling edge; drives one cycle, checks the visible output, returns at the next falling edge.
  task automatic step(input logic iv, input logic [31:0] sb, input logic [31:0] l, input logic [31:0] r,
                      input logic [3:0] rd, input logic ordy);
    res_t h;
    in_valid  = iv;
    sbox_out  = sb;
    l_in      = l;
    r_in      = r;
    round_in  = rd;
    out_ready = ordy;
    #1;
    check("out_valid_vs_model", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    if (out_valid && exp_q.size() != 0) begin
      h = exp_q[0];
      check("l_out_vs_model", l_out, h.l);
      check("r_out_vs_model", r_out, h.r);
      check("round_out_vs_model", {28'd0, round_out}, {28'd0, h.rd});
      if (out_ready) begin
        void'(exp_q.pop_front());
        rt_cnt++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(sb, l, r, rd));
      acc_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_acc;
    tab[0] = '{32'h5C82B597, 32'hCC00CCFF, 32'hF0AAF0AA, 4'd0,  32'hF0AAF0AA, 32'hEF4A6544};
    tab[1] = '{32'h5C82B597, 32'hCC00CCFF, 32'hF0AAF0AA, 4'd15, 32'hEF4A6544, 32'hF0AAF0AA};
    tab[2] = '{32'h80000000, 32'h00000000, 32'h00000000, 4'd3,  32'h00000000, 32'h00800000};
    tab[3] = '{32'h00000001, 32'h00000000, 32'h00000000, 4'd15, 32'h00000800, 32'h00000000};
    tab[4] = '{32'h00000000, 32'h12345678, 32'h9ABCDEF0, 4'd7,  32'h9ABCDEF0, 32'h12345678};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sbox_out = '0; l_in = '0; r_in = '0; round_in = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_l_out", l_out, 32'd0);
    check("rst_r_out", r_out, 32'd0);
    check("rst_round_out", {28'd0, round_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Known-answer vectors, one per cycle, 1-cycle latency
    for (int k = 0; k < 5; k++) begin
      step(1'b1, tab[k].sb, tab[k].l, tab[k].r, tab[k].rd, 1'b1);
      check("tab_out_valid", {31'd0, out_valid}, 32'd1);
      check("tab_l_out", l_out, tab[k].el);
      check("tab_r_out", r_out, tab[k].er);
      check("tab_round_out", {28'd0, round_out}, {28'd0, tab[k].rd});
    end
    step(1'b0, '0, '0, '0, '0, 1'b1);

    // Backpressure: push 3 words with out_ready low
    acc_cnt = 0; rt_cnt = 0;
`ifdef DES_MERGE_SKID_EN
    exp_acc = 2;
`else
    exp_acc = 1;
`endif
    for (int k = 0; k < 3; k++) step(1'b1, $urandom, $urandom, $urandom, 4'(k + 8), 1'b0);
    check("bp_accepted", acc_cnt, exp_acc);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 4; k++) step(1'b0, '0, '0, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, '0, '0, '0, '0, 1'b1);
    check("bp_retired", rt_cnt, exp_acc);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset while holding words
    step(1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 4'd1, 1'b0);
    step(1'b1, 32'h44444444, 32'h55555555, 32'h66666666, 4'd2, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_l_out", l_out, 32'd0);
    check("midrst_r_out", r_out, 32'd0);
    check("midrst_round_out", {28'd0, round_out}, 32'd0);
    exp_q.delete();
    in_valid = 1'b0; rst_n = 1'b1;
    #1;
    check("midrst_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    step(1'b1, 32'h5C82B597, 32'hCC00CCFF, 32'hF0AAF0AA, 4'd5, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, '0, '0, '0, '0, 1'b1);

    // 16 back-to-back rounds, no bubbles
    for (int k = 0; k < 16; k++) begin
      step(1'b1, $urandom, $urandom, $urandom, 4'(k), 1'b1);
      check("burst_in_ready", {31'd0, in_ready}, 32'd1);
      check("burst_out_valid", {31'd0, out_valid}, 32'd1);
      check("burst_round_out", {28'd0, round_out}, k);
    end
    step(1'b0, '0, '0, '0, '0, 1'b1);

    // Randomized traffic against the queue model
    acc_cnt = 0; rt_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 4) != 0, $urandom, $urandom, $urandom,
           4'($urandom_range(0, 15)), ($urandom % 3) != 0);
    end
    for (int k = 0; k < 6; k++) step(1'b0, '0, '0, '0, '0, 1'b1);
    check("rand_no_loss", rt_cnt, acc_cnt);
    check("rand_drained", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
